// File: rtl/counter_pkg.sv
// counter_pkg: shared encodings and the load-clamp helper for the counter family.
package counter_pkg;
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;
    function automatic logic [31:0] clamp_load(input logic [31:0] data, input logic [31:0] max);
        return (data > max) ? max : data;
    endfunction
endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: emits a tick on every PRESCALE-th enabled cycle; clr restarts the phase.
// Built only when UPDOWN_COUNTER_PRESCALE_EN is defined.
`ifdef UPDOWN_COUNTER_PRESCALE_EN
module counter_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    // A one-bit counter that never leaves 0 covers PRESCALE=1, making tick follow en.
    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [CW-1:0] r_cnt;
    assign tick = en & (r_cnt == CW'(PRESCALE - 1));
    always_ff @(posedge clk) begin
        if (rst || clr)
            r_cnt <= '0;
        else if (tick)
            r_cnt <= '0;
        else if (en)
            r_cnt <= r_cnt + 1'b1;
    end
endmodule
`endif

// File: rtl/updown_load_counter.sv
// updown_load_counter: loadable up/down counter over 0..MAX_VAL with wrap or saturate, tc and wrap flags.
// Defining UPDOWN_COUNTER_PRESCALE_EN adds a PRESCALE divider on the count enable.
module updown_load_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = (2**WIDTH) - 1,
    parameter int unsigned SATURATE = MODE_WRAP
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    , parameter int unsigned PRESCALE = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] dout,
    output logic             tc,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
    logic [WIDTH-1:0] r_dout;
    logic             r_wrap;
    logic             w_tick;
    logic             w_at_bound;
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .en   (en),
        .tick (w_tick)
    );
`else
    assign w_tick = en;
`endif
    assign w_at_bound = (up == DIR_UP) ? (r_dout == MAX) : (r_dout == '0);
    assign tc   = w_tick & ~load & w_at_bound;
    assign dout = r_dout;
    assign wrap = r_wrap;
    always_ff @(posedge clk) begin
        r_wrap <= 1'b0;
        if (rst)
            r_dout <= '0;
        else if (load)
            r_dout <= WIDTH'(clamp_load(32'(data), MAX_VAL));
        else if (w_tick) begin
            if (!w_at_bound)
                r_dout <= (up == DIR_UP) ? r_dout + 1'b1 : r_dout - 1'b1;
            else if (SATURATE == MODE_WRAP) begin
                r_dout <= (up == DIR_UP) ? '0 : MAX;
                r_wrap <= 1'b1;
            end
        end
    end
endmodule
